cnn_layer_sequencer: RTL
========================

Name: cnn_layer_sequencer

Overview:
- Programmable top-level layer scheduler for the CNN datapath; replaces the hard-wired TOPlvl/step schedule with a descriptor table of up to MAX_LAYERS layers.
- Walks the table, issues one job per (output channel, input channel) pair to the conv, maxp, dense and result engines over a start/done handshake, and generates pixel/weight base addresses.
- Ping-pongs feature maps between buffers A and B, then latches the classification result and raises stop.

Parameters:
- ADDR_PIX, 13, pixel RAM address width.
- ADDR_WEI, 9, weight RAM address width.
- MAX_LAYERS, 16, descriptor table depth (power of 2).
- LIDX_W, 4, log2(MAX_LAYERS).
- BUF_A_BASE, 0, pixel base of buffer A.
- BUF_B_BASE, 3136, pixel base of buffer B.
- DESC_W, 18, descriptor width: [1:0] type (0 CONV, 1 MAXP, 2 DENSE, 3 RESULT), [6:2] matrix, [11:7] in_ch-1, [16:12] out_ch-1, [17] globmaxp.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- go, input, 1, single-cycle start pulse; ignored while busy.
- cfg_we, input, 1, descriptor write strobe; ignored while busy.
- cfg_addr, input, LIDX_W, descriptor index.
- cfg_data, input, DESC_W, descriptor word.
- num_layers, input, LIDX_W+1, number of valid descriptors (1..MAX_LAYERS); sampled on go.
- busy, output, 1, high from go until DONE.
- stop, output, 1, high in DONE; cleared by the next go.
- result, output, 4, latched res_in; 4'hF until a RESULT job completes.
- eng_start, output, 4, one-hot single-cycle start: bit0 conv, bit1 maxp, bit2 dense, bit3 result.
- eng_done, input, 4, per-engine single-cycle done.
- res_in, input, 4, result engine class output; valid with eng_done[3].
- job_rd_base, output, ADDR_PIX, pixel read base.
- job_wr_base, output, ADDR_PIX, pixel write base.
- job_wei_base, output, ADDR_WEI, weight base.
- job_matrix, output, 5, input feature-map side length.
- job_first, output, 1, first input channel of an output channel; clear the accumulator.
- job_bias, output, 1, last input channel; add bias and write.
- job_globmaxp, output, 1, global-maxpool output mode.

Behaviour:
- Reset: state IDLE; all outputs 0 except result=4'hF; wei_ptr=0, layer=0, src=A, dst=B. Descriptor contents are not reset.
- States and transitions:
  - IDLE: on go, go to FETCH.
  - FETCH: read descriptor[layer], clear in_idx/out_idx/ch_idx, then ISSUE.
  - ISSUE: drive eng_start for one cycle, then WAIT.
  - WAIT: on eng_done of the issued engine, go to ADVANCE.
  - ADVANCE: step indices, then ISSUE, or NEXT at layer end.
  - NEXT: swap src/dst; layer+1; go to FETCH, or DONE when layer+1 == num_layers.
  - DONE: stop=1, busy=0; go returns to FETCH with layer=0, src=A, wei_ptr=0.
- go to first eng_start is 3 cycles. Job fields are registered in ISSUE and stay stable until the matching done.
- eng_done on a non-issued engine, or outside WAIT, is ignored. Done coincident with the start cycle is ignored.
- CONV:
  - Loop order: out_idx outer, in_idx inner.
  - rd = src + in_idx*m².
  - wr = dst + out_idx*m², or dst + out_idx when globmaxp=1.
  - wei = wei_ptr, and wei_ptr increments by 1 after every job.
  - job_first = (in_idx==0); job_bias = (in_idx==in_ch-1).
- MAXP:
  - One job per channel c < in_ch.
  - rd = src + c*m²; wr = dst + c*(m>>1)².
  - first=bias=0.
- DENSE: one job; rd=src, wr=dst, wei=wei_ptr; afterwards wei_ptr += in_ch*out_ch.
- RESULT: one job; rd=src. On done, result<=res_in, then DONE regardless of remaining layers.
- Arithmetic: m² is 10-bit unsigned. Products and sums are computed at 15 bits and truncated to ADDR_PIX / ADDR_WEI; wrap-around is permitted and not flagged.
- num_layers=0 is treated as 1.
- Reset mid-job returns to IDLE immediately; eng_start drops asynchronously.

Decomposition:
- cnn_seq_pkg:
  - Layer-type enum and descriptor field offsets/widths.
  - State enum (IDLE, FETCH, ISSUE, WAIT, ADVANCE, NEXT, DONE).
  - Engine one-hot constants.
- Sub-module cnn_desc_regfile: MAX_LAYERS x DESC_W, sync write, combinational read, write gated by !busy.

Test Plan:
- CONV in=1, out=2, m=28, num_layers=1, go -> 2 conv jobs with rd 0/0, wr 3136/3920, wei 0/1, first=bias=1 on both; then stop=1, result=4'hF.
- CONV in=2, out=2, m=28 -> 4 jobs:
  - rd 0, 784, 0, 784.
  - wr 3136, 3136, 3920, 3920.
  - first 1, 0, 1, 0; bias 0, 1, 0, 1.
  - wei 0..3.
- [CONV 1->4 m=28, MAXP 4ch m=28] -> MAXP jobs rd 3136+784c, wr 0+196c for c=0..3; src=B on the second layer.
- CONV globmaxp=1, in=1, out=3, m=7 -> wr 3136, 3137, 3138.
- [DENSE in=16 out=10, RESULT] with res_in=7 -> dense wei=wei_ptr; result=7, stop=1. A go pulse or cfg_we issued during WAIT -> no effect.
- rst_n low during WAIT of job 2 -> eng_start=0, busy=0, result=4'hF; a new go restarts from layer 0 with wei 0.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared constants for the CNN layer sequencer: layer types, descriptor field
// layout, FSM state encodings and engine start/done one-hot bits.
package cnn_seq_pkg;

    typedef enum logic [1:0] {
        LT_CONV   = 2'd0,
        LT_MAXP   = 2'd1,
        LT_DENSE  = 2'd2,
        LT_RESULT = 2'd3
    } layer_type_e;

    localparam int D_TYPE_LSB = 0;
    localparam int D_MAT_LSB  = 2;
    localparam int D_IN_LSB   = 7;
    localparam int D_OUT_LSB  = 12;
    localparam int D_GMP_BIT  = 17;
    localparam int D_FLD_W    = 5;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_ISSUE   = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_ADVANCE = 3'd4;
    localparam logic [2:0] ST_NEXT    = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic [3:0] ENG_CONV   = 4'b0001;
    localparam logic [3:0] ENG_MAXP   = 4'b0010;
    localparam logic [3:0] ENG_DENSE  = 4'b0100;
    localparam logic [3:0] ENG_RESULT = 4'b1000;

    function automatic logic [3:0] eng_onehot(input layer_type_e t);
        logic [3:0] v;
        case (t)
            LT_CONV:   v = ENG_CONV;
            LT_MAXP:   v = ENG_MAXP;
            LT_DENSE:  v = ENG_DENSE;
            LT_RESULT: v = ENG_RESULT;
            default:   v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cnn_desc_regfile.sv
// Layer descriptor table: synchronous write, combinational read. Writes are
// blocked while a schedule is running so the walked table cannot change.
module cnn_desc_regfile #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 18
) (
    input  logic          clk,
    input  logic          we,
    input  logic          busy,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Descriptor storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we && !busy) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Descriptor-driven layer scheduler: walks the layer table, issues one engine
// job per channel pair with generated base addresses, ping-pongs buffers A/B.
module cnn_layer_sequencer
    import cnn_seq_pkg::*;
#(
    parameter int ADDR_PIX   = 13,
    parameter int ADDR_WEI   = 9,
    parameter int MAX_LAYERS = 16,
    parameter int LIDX_W     = 4,
    parameter int BUF_A_BASE = 0,
    parameter int BUF_B_BASE = 3136,
    parameter int DESC_W     = 18
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                go,
    input  logic                cfg_we,
    input  logic [LIDX_W-1:0]   cfg_addr,
    input  logic [DESC_W-1:0]   cfg_data,
    input  logic [LIDX_W:0]     num_layers,
    output logic                busy,
    output logic                stop,
    output logic [3:0]          result,
    output logic [3:0]          eng_start,
    input  logic [3:0]          eng_done,
    input  logic [3:0]          res_in,
    output logic [ADDR_PIX-1:0] job_rd_base,
    output logic [ADDR_PIX-1:0] job_wr_base,
    output logic [ADDR_WEI-1:0] job_wei_base,
    output logic [4:0]          job_matrix,
    output logic                job_first,
    output logic                job_bias,
    output logic                job_globmaxp
);

    localparam logic [ADDR_PIX-1:0] BASE_A_C = ADDR_PIX'(BUF_A_BASE);
    localparam logic [ADDR_PIX-1:0] BASE_B_C = ADDR_PIX'(BUF_B_BASE);

    logic [2:0]          state_r;
    logic [LIDX_W-1:0]   layer_r;
    logic [LIDX_W:0]     nl_r;
    logic                src_b_r;
    logic [ADDR_WEI-1:0] wei_ptr_r;
    layer_type_e         type_r;
    logic [4:0]          matrix_r;
    logic [4:0]          inch_r;
    logic [4:0]          outch_r;
    logic                gmp_r;
    logic [4:0]          in_idx_r;
    logic [4:0]          out_idx_r;
    logic [3:0]          issued_r;

    logic [DESC_W-1:0]   desc_s;
    logic [LIDX_W:0]     nl_eff_s;
    logic                last_layer_s;
    logic                accept_s;
    logic [ADDR_PIX-1:0] src_base_s;
    logic [ADDR_PIX-1:0] dst_base_s;
    logic [9:0]          msq_s;
    logic [9:0]          hsq_s;
    logic [14:0]         rd_sum_s;
    logic [14:0]         conv_wr_off_s;
    logic [14:0]         mp_wr_off_s;
    logic [14:0]         dense_inc_s;
    logic [ADDR_PIX-1:0] job_rd_s;
    logic [ADDR_PIX-1:0] job_wr_s;
    logic                job_first_s;
    logic                job_bias_s;
    logic                job_gmp_s;

    cnn_desc_regfile #(
        .DEPTH (MAX_LAYERS),
        .AW    (LIDX_W),
        .DW    (DESC_W)
    ) u_desc (
        .clk   (clk),
        .we    (cfg_we),
        .busy  (busy),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .raddr (layer_r),
        .rdata (desc_s)
    );

    assign nl_eff_s = (num_layers == '0) ? (LIDX_W+1)'(1'b1) :
                      (num_layers > (LIDX_W+1)'(MAX_LAYERS)) ? (LIDX_W+1)'(MAX_LAYERS) :
                      num_layers;
    assign last_layer_s = (((LIDX_W+1)'(layer_r) + (LIDX_W+1)'(1'b1)) == nl_r);

    // A done coincident with the start pulse belongs to no job and is dropped.
    assign accept_s = (state_r == ST_WAIT) && (eng_start == 4'b0000) &&
                      ((eng_done & issued_r) != 4'b0000);

    assign src_base_s    = src_b_r ? BASE_B_C : BASE_A_C;
    assign dst_base_s    = src_b_r ? BASE_A_C : BASE_B_C;
    assign msq_s         = 10'(matrix_r) * 10'(matrix_r);
    assign hsq_s         = 10'(matrix_r >> 1) * 10'(matrix_r >> 1);
    assign rd_sum_s      = 15'(src_base_s) + 15'(in_idx_r) * 15'(msq_s);
    assign conv_wr_off_s = gmp_r ? 15'(out_idx_r) : 15'(out_idx_r) * 15'(msq_s);
    assign mp_wr_off_s   = 15'(in_idx_r) * 15'(hsq_s);
    assign dense_inc_s   = (15'(inch_r) + 15'd1) * (15'(outch_r) + 15'd1);

    // Address and flag selection for the job about to be issued.
    always_comb begin
        job_rd_s    = ADDR_PIX'(rd_sum_s);
        job_wr_s    = dst_base_s;
        job_first_s = 1'b0;
        job_bias_s  = 1'b0;
        job_gmp_s   = 1'b0;
        case (type_r)
            LT_CONV: begin
                job_wr_s    = ADDR_PIX'(15'(dst_base_s) + conv_wr_off_s);
                job_first_s = (in_idx_r == 5'd0);
                job_bias_s  = (in_idx_r == inch_r);
                job_gmp_s   = gmp_r;
            end
            LT_MAXP: job_wr_s = ADDR_PIX'(15'(dst_base_s) + mp_wr_off_s);
            default: job_rd_s = src_base_s;
        endcase
    end

    // Scheduler FSM with registered job fields and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            layer_r      <= '0;
            nl_r         <= (LIDX_W+1)'(1'b1);
            src_b_r      <= 1'b0;
            wei_ptr_r    <= '0;
            type_r       <= LT_CONV;
            matrix_r     <= 5'd0;
            inch_r       <= 5'd0;
            outch_r      <= 5'd0;
            gmp_r        <= 1'b0;
            in_idx_r     <= 5'd0;
            out_idx_r    <= 5'd0;
            issued_r     <= 4'b0000;
            busy         <= 1'b0;
            stop         <= 1'b0;
            result       <= 4'hF;
            eng_start    <= 4'b0000;
            job_rd_base  <= '0;
            job_wr_base  <= '0;
            job_wei_base <= '0;
            job_matrix   <= 5'd0;
            job_first    <= 1'b0;
            job_bias     <= 1'b0;
            job_globmaxp <= 1'b0;
        end else begin
            eng_start <= 4'b0000;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (go) begin
                        state_r   <= ST_FETCH;
                        layer_r   <= '0;
                        nl_r      <= nl_eff_s;
                        src_b_r   <= 1'b0;
                        wei_ptr_r <= '0;
                        busy      <= 1'b1;
                        stop      <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    type_r    <= layer_type_e'(desc_s[D_TYPE_LSB +: 2]);
                    matrix_r  <= desc_s[D_MAT_LSB +: D_FLD_W];
                    inch_r    <= desc_s[D_IN_LSB +: D_FLD_W];
                    outch_r   <= desc_s[D_OUT_LSB +: D_FLD_W];
                    gmp_r     <= desc_s[D_GMP_BIT];
                    in_idx_r  <= 5'd0;
                    out_idx_r <= 5'd0;
                    state_r   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    eng_start    <= eng_onehot(type_r);
                    issued_r     <= eng_onehot(type_r);
                    job_rd_base  <= job_rd_s;
                    job_wr_base  <= job_wr_s;
                    job_wei_base <= wei_ptr_r;
                    job_matrix   <= matrix_r;
                    job_first    <= job_first_s;
                    job_bias     <= job_bias_s;
                    job_globmaxp <= job_gmp_s;
                    state_r      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (accept_s) begin
                        if (type_r == LT_RESULT) begin
                            result <= res_in;
                        end
                        state_r <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    case (type_r)
                        LT_CONV: begin
                            wei_ptr_r <= wei_ptr_r + ADDR_WEI'(1'b1);
                            if (in_idx_r == inch_r) begin
                                in_idx_r <= 5'd0;
                                if (out_idx_r == outch_r) begin
                                    state_r <= ST_NEXT;
                                end else begin
                                    out_idx_r <= out_idx_r + 5'd1;
                                    state_r   <= ST_ISSUE;
                                end
                            end else begin
                                in_idx_r <= in_idx_r + 5'd1;
                                state_r  <= ST_ISSUE;
                            end
                        end
                        LT_MAXP: begin
                            if (in_idx_r == inch_r) begin
                                state_r <= ST_NEXT;
                            end else begin
                                in_idx_r <= in_idx_r + 5'd1;
                                state_r  <= ST_ISSUE;
                            end
                        end
                        LT_DENSE: begin
                            wei_ptr_r <= ADDR_WEI'(15'(wei_ptr_r) + dense_inc_s);
                            state_r   <= ST_NEXT;
                        end
                        default: begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                            stop    <= 1'b1;
                        end
                    endcase
                end
                ST_NEXT: begin
                    src_b_r <= ~src_b_r;
                    if (last_layer_s) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                        stop    <= 1'b1;
                    end else begin
                        layer_r <= layer_r + LIDX_W'(1'b1);
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
